// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode seven-segment display.
// Double-buffered value/mask/duty, per-slot blank interval and brightness duty.
module sevenseg_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned NDIG         = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_wr_en,
  input  logic [1:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_wr_ack,
  output logic [7:0]  AN,
  output logic [6:0]  o_seg,
  output logic        o_frame_tick,
  output logic [1:0]  o_state
);

  localparam int unsigned CW       = $clog2(SCAN_DIV);
  localparam int unsigned STEP     = (SCAN_DIV - BLANK_CYCLES) >> 4;
  localparam logic [2:0]  LAST_DIG = 3'(NDIG - 1);

  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_ON    = 2'd1,
    S_OFF   = 2'd2
  } state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] c_q, c_nxt;
  logic [2:0]    d_q, d_nxt;
  logic          slot_end, frame_end;

  logic [31:0]   st_value, sh_value, sh_value_nxt;
  logic [7:0]    st_mask, sh_mask, sh_mask_nxt;
  logic [3:0]    st_duty, sh_duty, sh_duty_nxt;

  logic [31:0]   c_ext, on_len;
  logic [3:0]    nib;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Write port: i_wr_en is a single-cycle strobe with no back-pressure; every
  // strobe is answered by exactly one o_wr_ack pulse on the following cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_value <= 32'h0;
      st_mask  <= 8'hFF;
      st_duty  <= 4'hF;
      o_wr_ack <= 1'b0;
    end else begin
      o_wr_ack <= i_wr_en;
      if (i_wr_en) begin
        case (i_wr_addr)
          2'd0:    st_value <= i_wr_data;
          2'd1:    st_mask  <= i_wr_data[7:0];
          2'd2:    st_duty  <= i_wr_data[3:0];
          default: ;
        endcase
      end
    end
  end

  // Everything below looks one cycle ahead so the registered outputs line up
  // with the counter value they describe.
  always_comb begin
    slot_end     = (c_q == CW'(SCAN_DIV - 1));
    frame_end    = slot_end && (d_q == LAST_DIG);
    c_nxt        = slot_end ? '0 : c_q + 1'b1;
    d_nxt        = slot_end ? d_q + 3'd1 : d_q;
    sh_value_nxt = frame_end ? st_value : sh_value;
    sh_mask_nxt  = frame_end ? st_mask  : sh_mask;
    sh_duty_nxt  = frame_end ? st_duty  : sh_duty;
    on_len       = STEP * ({28'd0, sh_duty_nxt} + 32'd1);
    c_ext        = 32'(c_nxt);
    nib          = sh_value_nxt[{d_nxt, 2'b00} +: 4];
  end

  always_comb begin
    state_nxt = S_OFF;
    an_nxt    = 8'hFF;
    seg_nxt   = 7'h7F;
    if (c_ext < BLANK_CYCLES) begin
      state_nxt = S_BLANK;
    end else if (c_ext < BLANK_CYCLES + on_len) begin
      state_nxt = S_ON;
    end
    if (state_nxt == S_ON) begin
      if (sh_mask_nxt[d_nxt]) an_nxt = ~(8'd1 << d_nxt);
      seg_nxt = decode(nib);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_BLANK;
      c_q          <= '0;
      d_q          <= 3'd0;
      sh_value     <= 32'h0;
      sh_mask      <= 8'hFF;
      sh_duty      <= 4'hF;
      AN           <= 8'hFF;
      o_seg        <= 7'h7F;
      o_frame_tick <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      c_q          <= c_nxt;
      d_q          <= d_nxt;
      sh_value     <= sh_value_nxt;
      sh_mask      <= sh_mask_nxt;
      sh_duty      <= sh_duty_nxt;
      AN           <= an_nxt;
      o_seg        <= seg_nxt;
      o_frame_tick <= frame_end;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl with SCAN_DIV=32, BLANK_CYCLES=4 (on_len = duty+1).
// Per-cycle reference of the scan pattern plus directed register-write vectors.
module tb_sevenseg_scan_ctrl;

  localparam int SD    = 32;
  localparam int BL    = 4;
  localparam int FRAME = 8 * SD;

  localparam logic [6:0] DEC_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_wr_en;
  logic [1:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        o_wr_ack;
  logic [7:0]  AN;
  logic [6:0]  o_seg;
  logic        o_frame_tick;
  logic [1:0]  o_state;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // reference state: cycles since reset release, staging and shown settings
  int          cyc      = 0;
  logic        wr_prev  = 1'b0;
  logic [31:0] st_value = 32'h0;
  logic [7:0]  st_mask  = 8'hFF;
  logic [3:0]  st_duty  = 4'hF;
  logic [31:0] sh_value = 32'h0;
  logic [7:0]  sh_mask  = 8'hFF;
  logic [3:0]  sh_duty  = 4'hF;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    int          chk_d;
    int          chk_c;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
  } vec_t;

  vec_t vecs [7];

  sevenseg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .NDIG(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .o_wr_ack     (o_wr_ack),
    .AN           (AN),
    .o_seg        (o_seg),
    .o_frame_tick (o_frame_tick),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit lit(input int p, input logic [3:0] du);
    int c;
    c = p % SD;
    return (c >= BL) && (c < BL + int'(du) + 1);
  endfunction

  function automatic logic [7:0] exp_an(input int p, input logic [7:0] m, input logic [3:0] du);
    int d;
    d = p / SD;
    if (lit(p, du) && m[d]) return ~(8'd1 << d);
    return 8'hFF;
  endfunction

  function automatic logic [6:0] exp_seg(input int p, input logic [31:0] v, input logic [3:0] du);
    int d;
    d = p / SD;
    if (lit(p, du)) return DEC_TAB[v[4*d +: 4]];
    return 7'h7F;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc      <= 0;
      wr_prev  <= 1'b0;
      st_value <= 32'h0;
      st_mask  <= 8'hFF;
      st_duty  <= 4'hF;
      sh_value <= 32'h0;
      sh_mask  <= 8'hFF;
      sh_duty  <= 4'hF;
    end else begin
      cyc     <= cyc + 1;
      wr_prev <= i_wr_en;
      if ((cyc + 1) % FRAME == 0) begin
        sh_value <= st_value;
        sh_mask  <= st_mask;
        sh_duty  <= st_duty;
      end
      if (i_wr_en) begin
        case (i_wr_addr)
          2'd0:    st_value <= i_wr_data;
          2'd1:    st_mask  <= i_wr_data[7:0];
          2'd2:    st_duty  <= i_wr_data[3:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_an",   {24'd0, AN},    {24'd0, exp_an(cyc % FRAME, sh_mask, sh_duty)});
      check("mon_seg",  {25'd0, o_seg}, {25'd0, exp_seg(cyc % FRAME, sh_value, sh_duty)});
      check("mon_tick", {31'd0, o_frame_tick}, {31'd0, (cyc > 0) && (cyc % FRAME == 0)});
      check("mon_ack",  {31'd0, o_wr_ack}, {31'd0, wr_prev});
    end
  end

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while ((cyc % FRAME) != p && n < 2 * FRAME + 10) begin
      @(negedge clk);
      n++;
    end
    if ((cyc % FRAME) != p) begin
      checks++;
      failures++;
      $display("FAIL wait_pos: got pos %0d expected pos %0d", cyc % FRAME, p);
    end
  endtask

  task automatic next_frame_pos(input int p);
    @(negedge clk);
    wait_pos(0);
    wait_pos(p);
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
    i_wr_en   = 1'b1;
    i_wr_addr = addr;
    i_wr_data = data;
    @(negedge clk);
    check("wr_ack", {31'd0, o_wr_ack}, 32'd1);
    i_wr_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd0, 32'hFEDCBA98, 0, 4,  8'hFE, 7'b0000000};
    vecs[1] = '{2'd3, 32'h12345678, 7, 19, 8'h7F, 7'b0111000};
    vecs[2] = '{2'd1, 32'h00000005, 2, 10, 8'hFB, 7'b0001000};
    vecs[3] = '{2'd2, 32'h00000000, 0, 5,  8'hFF, 7'h7F};
    vecs[4] = '{2'd2, 32'hFFFFFFF7, 2, 11, 8'hFB, 7'b0001000};
    vecs[5] = '{2'd1, 32'h000000FF, 3, 12, 8'hFF, 7'h7F};
    vecs[6] = '{2'd0, 32'h01234567, 7, 4,  8'h7F, 7'b0000001};

    rstn      = 1'b0;
    i_wr_en   = 1'b0;
    i_wr_addr = 2'd0;
    i_wr_data = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_an",   {24'd0, AN},    32'hFF);
    check("rst_seg",  {25'd0, o_seg}, 32'h7F);
    check("rst_ack",  {31'd0, o_wr_ack}, 32'd0);
    check("rst_tick", {31'd0, o_frame_tick}, 32'd0);
    rstn   = 1'b1;
    mon_en = 1'b1;

    wait_pos(3);
    check("idle_blank_an", {24'd0, AN}, 32'hFF);
    wait_pos(4);
    check("idle_d0_an",  {24'd0, AN},    32'hFE);
    check("idle_d0_seg", {25'd0, o_seg}, 32'h01);
    wait_pos(20);
    check("idle_off_an", {24'd0, AN}, 32'hFF);
    next_frame_pos(0);
    check("first_tick", {31'd0, o_frame_tick}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      wait_pos(3 * SD + 7);
      do_write(vecs[i].addr, vecs[i].data);
      next_frame_pos(vecs[i].chk_d * SD + vecs[i].chk_c);
      check($sformatf("vec%0d_an", i),  {24'd0, AN},    {24'd0, vecs[i].exp_an});
      check($sformatf("vec%0d_seg", i), {25'd0, o_seg}, {25'd0, vecs[i].exp_seg});
    end

    // write sampled in the cycle o_frame_tick is high
    next_frame_pos(0);
    check("tick_cycle", {31'd0, o_frame_tick}, 32'd1);
    do_write(2'd0, 32'h55555555);
    wait_pos(4);
    check("tickwr_old_seg", {25'd0, o_seg}, 32'h0F);
    next_frame_pos(4);
    check("tickwr_new_seg", {25'd0, o_seg}, 32'h24);

    // write sampled on the very edge that loads the shadow
    wait_pos(FRAME - 1);
    do_write(2'd0, 32'h33333333);
    wait_pos(4);
    check("edgewr_old_seg", {25'd0, o_seg}, 32'h24);
    next_frame_pos(4);
    check("edgewr_new_seg", {25'd0, o_seg}, 32'h06);

    // back-to-back strobes each get their own ack
    wait_pos(40);
    do_write(2'd3, 32'h0);
    do_write(2'd3, 32'h0);
    @(negedge clk);
    check("b2b_ack_low", {31'd0, o_wr_ack}, 32'd0);

    // reset mid-slot, digit 5 lit at c=10 (duty 7)
    wait_pos(5 * SD + 10);
    check("pre_rst_an", {24'd0, AN}, 32'hDF);
    #2 rstn = 1'b0;
    #1;
    check("midrst_an",  {24'd0, AN},    32'hFF);
    check("midrst_seg", {25'd0, o_seg}, 32'h7F);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_pos(4);
    check("post_rst_d0_an",  {24'd0, AN},    32'hFE);
    check("post_rst_d0_seg", {25'd0, o_seg}, 32'h01);
    wait_pos(7 * SD + 19);
    check("post_rst_d7_an",  {24'd0, AN},    32'h7F);
    check("post_rst_d7_seg", {25'd0, o_seg}, 32'h01);
    wait_pos(7 * SD + 20);
    check("post_rst_d7_off", {24'd0, AN}, 32'hFF);
    next_frame_pos(0);
    check("post_rst_tick", {31'd0, o_frame_tick}, 32'd1);

    @(negedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit common-anode seven-segment display on the Nexys A7 (AN[7:0], CA..CG).
- Owns the shared segment bus. Each frame, every digit gets one fixed time slot, with an anti-ghosting blank interval and a programmable brightness duty.
- Sits in the SoC GPIO region in the clk_core domain. Configured through a simple write port driven by the bus bridge.
- Display contents are double-buffered and swap only at frame boundaries, so the display never tears.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot. Must be >= BLANK_CYCLES+16.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off.
- NDIG, 8: number of digits. Fixed at 8; any other value is unsupported.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- i_wr_en  in  1  write strobe, single cycle
- i_wr_addr  in  2  register select
- i_wr_data  in  32  write data
- o_wr_ack  out  1  one-cycle acknowledge, asserted the cycle after i_wr_en
- AN  out  8  anodes, active low, bit d = digit d
- o_seg  out  7  segments {CA,CB,CC,CD,CE,CF,CG} = {a..g}, active low
- o_frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low, and every register clears immediately on rstn low.
- Reset values:
  - AN=8'hFF, o_seg=7'h7F, o_wr_ack=0, o_frame_tick=0.
  - Staging and shadow: value=32'h0, mask=8'hFF, duty=4'hF.
  - Digit index d=0, slot counter c=0, state S_BLANK.
- Registers (write-only, staging copies):
  - addr 0: value. Digit d shows nibble value[4d+3:4d].
  - addr 1: mask[7:0]. A 0 bit keeps that digit dark.
  - addr 2: duty[3:0]. Other bits ignored.
  - addr 3: reserved. Write is acked and has no effect.
- Shadow copies (value, mask, duty) drive the display.
  - They load from staging only when the last slot of a frame ends.
  - A write in the same cycle as that load lands in staging only; the shadow takes the pre-write staging value, and the new value appears one frame later.
- Counters:
  - c counts 0..SCAN_DIV-1 and wraps.
  - On wrap, d increments; on d 7->0 wrap, the frame boundary fires.
  - The frame boundary pulses o_frame_tick for 1 cycle and performs the shadow load.
  - Frame length is exactly 8*SCAN_DIV cycles, independent of mask.
- Slot timing: on_len = ((SCAN_DIV-BLANK_CYCLES)>>4)*(duty+1). This is always <= SCAN_DIV-BLANK_CYCLES; compute on_len at full width, with no truncation.
- State machine, per slot:
  - S_BLANK (c < BLANK_CYCLES): AN=FF, o_seg=7F.
  - S_ON (BLANK_CYCLES <= c < BLANK_CYCLES+on_len): AN[d]=0 if mask[d], all other AN bits 1; o_seg = decode(nibble d).
  - S_OFF: rest of the slot, AN=FF, o_seg=7F.
  - On c wrap, go to S_BLANK with the next d.
- Output timing: AN and o_seg are registered and aligned so they reflect the c value in the same cycle. On the first clk after rstn rises, c=0.
- Decode (active low, a..g MSB-first):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Glitch rule: AN and o_seg change only at S_BLANK / S_ON / S_OFF boundaries. At most one AN bit is ever low.
- Reset mid-frame: outputs go to reset values asynchronously; scanning restarts at digit 0, c=0.
- Writes: no back-pressure. Every i_wr_en gets exactly one o_wr_ack, including back-to-back writes.

Test Plan (SCAN_DIV=32, BLANK_CYCLES=4, so on_len=duty+1):
1. Reset then idle, duty=F, value=0 -> in each 32-cycle slot: AN=FF for c 0-3; AN has one bit low (FE, FD, ... 7F in order) for c 4-19 with o_seg=0000001; AN=FF for c 20-31. o_frame_tick pulses every 256 cycles.
2. Write value=32'hFEDCBA98 mid-frame -> current frame still shows 0. Next frame: digit0=8 (0000000), digit7=F (0111000). o_wr_ack high exactly 1 cycle after the write.
3. Write mask=8'h05 -> at the next frame only AN[0] and AN[2] ever go low. Slots 1 and 3-7 stay AN=FF for all 32 cycles, and frame period stays 256.
4. Write duty=0 -> next frame each enabled digit is lit for exactly 1 cycle (c=4). duty=7 gives 8 cycles (c 4-11).
5. Write to addr 0 in the exact cycle of o_frame_tick -> shadow shows the old staging value for that frame and the new value from the following frame.
6. Assert rstn low at c=10 of digit 5 -> AN=FF and o_seg=7F the same cycle. After release, scanning restarts at digit 0, c=0, with value=0, mask=FF, duty=F.
